// File: rtl/fetch_stage.sv
// fetch_stage -- single-issue instruction fetch with an IF/ID pipeline register.
//
// Keeps the PC and issues one request at a time to instruction memory.
// A decode stall either holds the IF/ID register, or parks a word that has
// just arrived in a one-entry buffer (HOLD). A redirect flushes IF/ID. If a
// request is still outstanding when the redirect arrives, the stage waits for
// that request to complete (DRAIN) and throws its data away before it
// refetches at the new target.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   imem_req      fetch request (never asserted while rst=1 or in HOLD)
//   imem_addr     word-aligned fetch address (the current pc)
//   imem_ready    imem_rdata is valid; completes the outstanding request
//   imem_rdata    fetched instruction word
//   stall         decode cannot accept; hold IF/ID
//   redirect      one-cycle pulse for a taken branch/jump
//   redirect_pc   redirect target (low two bits are forced to zero)
//   if_id_valid   IF/ID holds a live instruction
//   if_id_instr   IF/ID instruction word
//   if_id_pc4     address of the IF/ID instruction plus 4
//   opcode        if_id_instr[31:26]
//   misalign_err  sticky: some redirect target had nonzero low bits
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode,
  output logic        misalign_err
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buffer, buffer_n;
  logic [31:0] pending_pc, pending_n;
  logic        valid_n;
  logic [31:0] instr_n, pc4_n;
  logic        err_n;

  logic [31:0] pc_inc;
  logic [31:0] target;

  // pc + 4 wraps naturally in 32 bits
  assign pc_inc = pc + 32'd4;
  assign target = {redirect_pc[31:2], 2'b00};

  // imem_addr is always pc. In DRAIN, pc still holds the address of the
  // abandoned request, which keeps the address stable until it completes.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    buffer_n  = buffer;
    pending_n = pending_pc;
    valid_n   = if_id_valid;
    instr_n   = if_id_instr;
    pc4_n     = if_id_pc4;
    err_n     = misalign_err | (redirect & (redirect_pc[1:0] != 2'b00));

    case (state)
      FETCH: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (imem_ready) begin
            // request completes this cycle: drop its data, go to target now
            pc_n    = target;
            state_n = FETCH;
          end else begin
            // request still in flight: wait for it before refetching
            pending_n = target;
            state_n   = DRAIN;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buffer_n = imem_rdata;
            state_n  = HOLD;
          end else begin
            instr_n = imem_rdata;
            pc4_n   = pc_inc;
            valid_n = 1'b1;
            pc_n    = pc_inc;
          end
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          // buffered word is dropped simply by leaving HOLD without using it
          pc_n    = target;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (!stall) begin
          instr_n = buffer;
          pc4_n   = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          state_n = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (imem_ready) begin
            // old request is gone this cycle; the newest target wins
            pc_n    = target;
            state_n = FETCH;
          end else begin
            pending_n = target;
          end
        end else if (imem_ready) begin
          pc_n    = pending_pc;
          state_n = FETCH;
        end
      end

      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= 32'd0;
      buffer       <= 32'd0;
      pending_pc   <= 32'd0;
      if_id_valid  <= 1'b0;
      if_id_instr  <= 32'd0;
      if_id_pc4    <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      buffer       <= buffer_n;
      pending_pc   <= pending_n;
      if_id_valid  <= valid_n;
      if_id_instr  <= instr_n;
      if_id_pc4    <= pc4_n;
      misalign_err <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .opcode(opcode), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model, phrased in terms of what the fetch unit owes decode:
  // a queue of at most one word parked by a stall, and a queue of at most one
  // redirect target waiting behind an abandoned memory request.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] parked[$];
  logic [31:0] waiting[$];

  function automatic logic m_req(input logic r);
    return !r && (parked.size() == 0);
  endfunction

  task automatic model_edge(input logic r, input logic rdy, input logic [31:0] rd,
                            input logic st, input logic rdir, input logic [31:0] rpc);
    logic [31:0] al;
    al = rpc & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
      parked.delete(); waiting.delete();
      return;
    end
    if (rdir && (rpc % 4 != 0)) m_err = 1;
    if (waiting.size() != 0) begin
      if (rdir) begin
        m_valid = 0;
        if (rdy) begin waiting.delete(); m_pc = al; end
        else waiting[0] = al;
      end else if (rdy) m_pc = waiting.pop_front();
    end else if (parked.size() != 0) begin
      if (rdir) begin parked.delete(); m_pc = al; m_valid = 0; end
      else if (!st) begin
        m_instr = parked.pop_front(); m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      end
    end else begin
      if (rdir) begin
        m_valid = 0;
        if (rdy) m_pc = al; else waiting.push_back(al);
      end else if (rdy) begin
        if (st) parked.push_back(rd);
        else begin m_instr = rd; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; end
      end else if (!st) m_valid = 0;
    end
  endtask

  // One clock: drive inputs after the falling edge, check request outputs,
  // advance model at the rising edge, then check the registered outputs.
  task automatic cyc(input logic r, input logic rdy, input logic [31:0] rd,
                     input logic st, input logic rdir, input logic [31:0] rpc);
    logic er;
    @(negedge clk);
    rst = r; imem_ready = rdy; imem_rdata = rd; stall = st;
    redirect = rdir; redirect_pc = rpc;
    #1;
    er = m_req(r);
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    if (er) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_edge(r, rdy, rd, st, rdir, rpc);
    #1;
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  initial begin
    // reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1234_5678, 1, 1, 32'h0000_0043);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);

    // streaming: addresses 0,4,8
    cyc(0, 1, 32'h0000_0001, 0, 0, 0);
    chk("seq_pc4_a", if_id_pc4, 32'd4);
    cyc(0, 1, 32'h0000_0002, 0, 0, 0);
    chk("seq_pc4_b", if_id_pc4, 32'd8);
    cyc(0, 1, 32'h0000_0003, 0, 0, 0);
    chk("seq_pc4_c", if_id_pc4, 32'd12);
    chk("seq_valid", {31'd0, if_id_valid}, 32'd1);

    // stall for three cycles as 0x8C220004 arrives
    cyc(0, 1, 32'h8C22_0004, 1, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_ifid", if_id_instr, 32'h0000_0003);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("unhold_instr", if_id_instr, 32'h8C22_0004);
    chk("unhold_opcode", {26'd0, opcode}, 32'h23);
    chk("unhold_pc4", if_id_pc4, 32'd16);

    // redirect under stall
    cyc(0, 1, 32'hAAAA_AAAA, 1, 1, 32'h0000_0040);
    chk("rdir_stall_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rdir_stall_addr", imem_addr, 32'h40);

    // redirect behind a pending request at 0x10
    cyc(0, 1, 0, 0, 1, 32'h0000_0010);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0080);
    chk("drain_addr_a", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_addr_b", imem_addr, 32'h10);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drain_done_addr", imem_addr, 32'h80);
    chk("drain_discard", {31'd0, if_id_valid}, 32'd0);

    // misaligned redirect and pc wrap
    cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFE);
    chk("mis_addr", imem_addr, 32'hFFFF_FFFC);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    cyc(0, 1, 32'h2000_0005, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_pc4", if_id_pc4, 32'd0);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // reset in the middle of DRAIN
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0100);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_drain_req", {31'd0, imem_req}, 32'd0);
    chk("rst_drain_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_drain_addr", imem_addr, 32'd0);
    chk("rst_drain_err", {31'd0, misalign_err}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, rdy, st, rdir;
      logic [31:0] rd, rpc;
      r    = ($urandom_range(0, 99) == 0);
      rdy  = ($urandom_range(0, 1) == 1);
      st   = ($urandom_range(0, 9) < 3);
      rdir = ($urandom_range(0, 9) == 0);
      rd   = $urandom;
      rpc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cyc(r, rdy, rd, st, rdir, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
